// File: rtl/mpram_pkg.sv
// Shared types and helpers for the multiport RAM.
// Contents: FSM state enum, port-count limit, even-parity helper.
package mpram_pkg;

  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned PAR_MAX_W = 64;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  // Even parity bit: makes the total number of ones (data + bit) even.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mpram_write_arbiter.sv
// Combinational write arbiter for the multiport RAM.
// A writer loses when any lower-index writer targets the same address,
// so exactly one write per address survives (lowest index wins).
// Ports:
//   en          - arbitration enable (RAM running, not in reset)
//   req, we     - per-port request and write enable
//   addr        - flattened addresses, port p = addr[p*AW +: AW]
//   grant_c     - port's write commits this cycle
//   collision_c - port's write was dropped
module mpram_write_arbiter #(
  parameter int unsigned AW    = 12,
  parameter int unsigned PORTS = 4
) (
  input  logic                  en,
  input  logic [PORTS-1:0]      req,
  input  logic [PORTS-1:0]      we,
  input  logic [PORTS*AW-1:0]   addr,
  output logic [PORTS-1:0]      grant_c,
  output logic [PORTS-1:0]      collision_c
);

  logic [PORTS-1:0] wr_c;

  // Priority by address compare against every lower-index writer.
  always_comb begin
    wr_c        = req & we & {PORTS{en}};
    grant_c     = '0;
    collision_c = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_c[q] && wr_c[p] && (addr[q*AW +: AW] == addr[p*AW +: AW])) begin
          collision_c[p] = 1'b1;
        end
      end
      grant_c[p] = wr_c[p] & ~collision_c[p];
    end
  end

endmodule

// File: rtl/multiport_ram_arb.sv
// N-port synchronous RAM with per-port request/valid handshake, lowest-index
// write arbitration, write-first forwarding and an optional post-reset zero sweep.
// Optional feature: define MPRAM_PARITY_EN to store an even-parity bit per word
// and flag read parity errors on rerr (otherwise rerr is tied low).
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   req, we     - per-port request / write enable
//   addr, wdata - flattened per-port address and write data
//   rdata       - flattened registered read data (held when rvalid is low)
//   rvalid      - one-cycle pulse per accepted request
//   collision   - one-cycle pulse when a port's write lost arbitration
//   busy        - zero-fill sweep in progress, requests ignored
//   rerr        - read parity error, aligned with rvalid
module multiport_ram_arb
  import mpram_pkg::*;
#(
  parameter int unsigned DW            = 12,
  parameter int unsigned AW            = 12,
  parameter int unsigned PORTS         = 4,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORTS-1:0]      req,
  input  logic [PORTS-1:0]      we,
  input  logic [PORTS*AW-1:0]   addr,
  input  logic [PORTS*DW-1:0]   wdata,
  output logic [PORTS*DW-1:0]   rdata,
  output logic [PORTS-1:0]      rvalid,
  output logic [PORTS-1:0]      collision,
  output logic                  busy,
  output logic [PORTS-1:0]      rerr
);

  localparam int unsigned DEPTH = 2**AW;
`ifdef MPRAM_PARITY_EN
  localparam int unsigned SW = DW + 1;
`else
  localparam int unsigned SW = DW;
`endif

  if (PORTS < 1 || PORTS > MAX_PORTS) begin : g_bad_ports
    $error("multiport_ram_arb: PORTS out of range");
  end

  // Stored word format: {parity, data} when parity is enabled, else data.
  function automatic logic [SW-1:0] encode(input logic [DW-1:0] d);
`ifdef MPRAM_PARITY_EN
    return {parity(PAR_MAX_W'(d)), d};
`else
    return d;
`endif
  endfunction

  logic [SW-1:0]    mem [DEPTH];
  state_t           state, state_nx;
  logic [AW-1:0]    sweep, sweep_nx;
  logic             run_c;
  logic [PORTS-1:0] grant_c, coll_c;
  logic [SW-1:0]    rd_word_c [PORTS];
  logic [DW-1:0]    rd_data_c [PORTS];

  // Next state: sweep one word per cycle, leave after the last word.
  always_comb begin
    state_nx = state;
    sweep_nx = sweep;
    case (state)
      S_INIT: begin
        sweep_nx = sweep + AW'(1);
        if (&sweep) begin
          state_nx = S_RUN;
          sweep_nx = '0;
        end
      end
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  // State, sweep counter and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      sweep <= '0;
      busy  <= (INIT_ON_RESET != 0);
    end else begin
      state <= state_nx;
      sweep <= sweep_nx;
      busy  <= (state_nx == S_INIT);
    end
  end

  assign run_c = (state == S_RUN) && !reset;

  mpram_write_arbiter #(
    .AW    (AW),
    .PORTS (PORTS)
  ) u_arb (
    .en          (run_c),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .grant_c     (grant_c),
    .collision_c (coll_c)
  );

  // Storage: sweep writes during init, granted port writes while running.
  always_ff @(posedge clk) begin
    if (state == S_INIT && !reset) begin
      mem[sweep] <= '0;
    end
    for (int p = 0; p < PORTS; p++) begin
      if (grant_c[p]) begin
        mem[addr[p*AW +: AW]] <= encode(wdata[p*DW +: DW]);
      end
    end
  end

  // Read path with write-first forwarding from this cycle's granted writer.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_word_c[p] = mem[addr[p*AW +: AW]];
      for (int q = 0; q < PORTS; q++) begin
        if (grant_c[q] && (addr[q*AW +: AW] == addr[p*AW +: AW])) begin
          rd_word_c[p] = encode(wdata[q*DW +: DW]);
        end
      end
      rd_data_c[p] = rd_word_c[p][DW-1:0];
    end
  end

`ifdef MPRAM_PARITY_EN
  logic [PORTS-1:0] rd_err_c;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_err_c[p] = ^rd_word_c[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rerr <= '0;
    end else begin
      rerr <= req & {PORTS{run_c}} & rd_err_c;
    end
  end
`else
  assign rerr = '0;
`endif

  // Output registers; rdata only updates on accepted requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata     <= '0;
      rvalid    <= '0;
      collision <= '0;
    end else begin
      rvalid    <= req & {PORTS{run_c}};
      collision <= coll_c;
      for (int p = 0; p < PORTS; p++) begin
        if (run_c && req[p]) begin
          rdata[p*DW +: DW] <= rd_data_c[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_ram_arb.sv
// Scoreboard bench for multiport_ram_arb (DW=12, AW=8, 4 ports, zero sweep on).
module tb_multiport_ram_arb;

  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = 8;
  localparam int unsigned P     = 4;
  localparam int unsigned DEPTH = 2**AW;

  logic              clk = 1'b0;
  logic              reset;
  logic [P-1:0]      req, we;
  logic [P*AW-1:0]   addr;
  logic [P*DW-1:0]   wdata;
  logic [P*DW-1:0]   rdata;
  logic [P-1:0]      rvalid, collision, rerr;
  logic              busy;

  always #5 clk = ~clk;

  multiport_ram_arb #(
    .DW(DW), .AW(AW), .PORTS(P), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .collision(collision), .busy(busy), .rerr(rerr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    logic          err;
  } exp_t;

  exp_t          exp_q [P][$];
  logic [DW-1:0] model_mem [DEPTH];
  int            n_err = 0;
  int            n_chk = 0;

  logic [P-1:0]  st_req, st_we;
  logic [AW-1:0] st_addr [P];
  logic [DW-1:0] st_wdata [P];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_st();
    st_req = '0;
    st_we  = '0;
    for (int p = 0; p < P; p++) begin
      st_addr[p]  = '0;
      st_wdata[p] = '0;
    end
  endtask

  // Drive one cycle of requests; expected responses come from the RAM rules.
  task automatic issue();
    int   win [int];
    exp_t e;
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++) begin
      if (st_req[p] && st_we[p] && !win.exists(int'(st_addr[p]))) win[int'(st_addr[p])] = p;
    end
    for (int p = 0; p < P; p++) begin
      if (st_req[p]) begin
        int a = int'(st_addr[p]);
        e.coll = st_we[p] && win.exists(a) && (win[a] != p);
        e.data = win.exists(a) ? st_wdata[win[a]] : model_mem[a];
        e.err  = 1'b0;
        exp_q[p].push_back(e);
      end
    end
    foreach (win[a]) model_mem[a] = st_wdata[win[a]];
    req = st_req;
    we  = st_we;
    for (int p = 0; p < P; p++) begin
      addr[p*AW +: AW]  = st_addr[p];
      wdata[p*DW +: DW] = st_wdata[p];
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req = '0;
    we  = '0;
  endtask

  // Reset, optionally re-reset at a given sweep count, and measure busy length.
  task automatic reset_and_sweep(input int abort_at);
    int cnt;
    int guard;
    bit aborted;
    cnt = 0; guard = 0; aborted = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1; req = '0; we = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_collision", 32'(collision), 32'h0);
    chk("reset_rerr", 32'(rerr), 32'h0);
    chk("reset_rdata_p0", 32'(rdata[DW-1:0]), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    cnt = 1;
    while (guard < 3*DEPTH) begin
      guard++;
      if (!aborted && abort_at >= 0 && cnt - 1 == abort_at) begin
        aborted = 1'b1;
        reset = 1'b1; req = '0; we = '0;
        @(negedge clk);
        chk("midsweep_reset_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        cnt = 1;
      end
      req   = P'($urandom);
      we    = P'($urandom);
      addr  = (P*AW)'($urandom);
      wdata = (P*DW)'({$urandom, $urandom});
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    req = '0;
    we  = '0;
    chk("busy_cycles", 32'(cnt), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      clear_st();
      st_req = '1;
      for (int p = 0; p < P; p++) st_addr[p] = AW'((a + p) % DEPTH);
      issue();
    end
    idle();
  endtask

  // Monitor: every rvalid pops and checks one expected response.
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < P; p++) begin
        if (rvalid[p] === 1'b1) begin
          if (exp_q[p].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_rvalid port %0d: got rvalid=1 expected 0 at %0t", p, $time);
          end else begin
            exp_t e;
            e = exp_q[p].pop_front();
            chk($sformatf("rdata_p%0d", p), 32'(rdata[p*DW +: DW]), 32'(e.data));
            chk($sformatf("collision_p%0d", p), 32'(collision[p]), 32'(e.coll));
            chk($sformatf("rerr_p%0d", p), 32'(rerr[p]), 32'(e.err));
          end
        end else begin
          chk($sformatf("idle_collision_p%0d", p), 32'(collision[p]), 32'h0);
          chk($sformatf("idle_rerr_p%0d", p), 32'(rerr[p]), 32'h0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    clear_st();

    // Power-on sweep then every word reads zero.
    reset_and_sweep(-1);
    read_all();

    // Two writers, same word: port 0 wins, port 2 sees winner data.
    clear_st();
    st_req = 4'b0101; st_we = 4'b0101;
    st_addr[0] = 8'h10; st_wdata[0] = 12'hABC;
    st_addr[2] = 8'h10; st_wdata[2] = 12'h123;
    issue(); idle(); @(negedge clk);
    chk("collide_vector", 32'(collision), 32'h4);
    chk("collide_p2_rdata", 32'(rdata[2*DW +: DW]), 32'hABC);
    chk("collide_rvalid", 32'(rvalid), 32'h5);

    // Write-first forwarding to another port.
    clear_st();
    st_req = 4'b1010; st_we = 4'b0010;
    st_addr[1] = 8'h20; st_wdata[1] = 12'h5A5;
    st_addr[3] = 8'h20;
    issue(); idle(); @(negedge clk);
    chk("fwd_p3_rdata", 32'(rdata[3*DW +: DW]), 32'h5A5);
    chk("fwd_p3_rvalid", 32'(rvalid[3]), 32'h1);

    // Four writes to distinct words all commit.
    clear_st();
    st_req = '1; st_we = '1;
    for (int p = 0; p < P; p++) begin
      st_addr[p]  = AW'(p);
      st_wdata[p] = DW'(p + 1);
    end
    issue(); idle(); @(negedge clk);
    chk("distinct_collision", 32'(collision), 32'h0);
    clear_st();
    st_req = '1;
    for (int p = 0; p < P; p++) st_addr[p] = AW'((p + 1) % 4);
    st_addr[1] = 8'h10;
    issue(); idle(); @(negedge clk);
    chk("distinct_rd_p0", 32'(rdata[0 +: DW]), 32'h2);
    chk("stored_winner_0x10", 32'(rdata[DW +: DW]), 32'hABC);
    chk("distinct_rd_p3", 32'(rdata[3*DW +: DW]), 32'h1);

`ifdef MPRAM_PARITY_EN
    // Corrupt a stored bit behind the RAM's back; the read must flag it.
    clear_st();
    st_req[0] = 1'b1; st_we[0] = 1'b1; st_addr[0] = 8'h30; st_wdata[0] = 12'h3C3;
    issue(); idle();
    dut.mem[8'h30] = dut.mem[8'h30] ^ 13'h001;
    model_mem[8'h30] = model_mem[8'h30] ^ 12'h001;
    clear_st();
    st_req[1] = 1'b1; st_addr[1] = 8'h30;
    issue();
    exp_q[1][exp_q[1].size()-1].err = 1'b1;
    idle(); @(negedge clk);
    chk("parity_rerr_p1", 32'(rerr[1]), 32'h1);
`endif

    // Re-reset mid-sweep: sweep restarts and all contents return to zero.
    reset_and_sweep(7);
    read_all();

    // Random traffic over a narrow window to force collisions and forwarding.
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < P; p++) begin
        st_req[p]   = ($urandom_range(0, 9) < 7);
        st_we[p]    = $urandom_range(0, 1) == 1;
        st_addr[p]  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        st_wdata[p] = DW'($urandom);
      end
      issue();
    end
    idle();
    repeat (3) @(negedge clk);

    for (int p = 0; p < P; p++) chk($sformatf("drained_p%0d", p), 32'(exp_q[p].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
